keyboard_code_ctrl: RTL and testbench
=====================================

KEYBOARD_CODE_CTRL -- requirements
Module: keyboard_code_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, event FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, max clk cycles allowed between prefix byte and next byte.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port rx_done_tick  input  1  one-cycle strobe; dout holds a received PS/2 byte.
REQ-006 SHALL have port dout  input  8  received scan-code byte, sampled only when rx_done_tick=1.
REQ-007 SHALL have port key_ready  input  1  consumer accepts head event.
REQ-008 SHALL have port key_valid  output  1  FIFO head event present.
REQ-009 SHALL have port key_code  output  8  head event scan code (prefixes stripped).
REQ-010 SHALL have port key_ext  output  1  head event was E0-prefixed.
REQ-011 SHALL have port key_release  output  1  head event was F0-prefixed (break).
REQ-012 SHALL have port overflow  output  1  one-cycle pulse when an event is dropped on full FIFO.

Function
REQ-013 SHALL decode with FSM states IDLE, EXT, BRK, EXT_BRK; state changes only on cycles with rx_done_tick=1, except timeout (REQ-019).
REQ-014 IDLE: E0 -> EXT; F0 -> BRK; AA, FA, FE, EE, 00, FF -> discarded, stay IDLE; other byte -> emit {code, ext=0, rel=0}, stay IDLE.
REQ-015 EXT: E0 -> stay EXT; F0 -> EXT_BRK; other -> emit {code, ext=1, rel=0}, -> IDLE.
REQ-016 BRK: F0 -> stay BRK; E0 -> EXT_BRK; other -> emit {code, ext=0, rel=1}, -> IDLE.
REQ-017 EXT_BRK: E0 or F0 -> stay EXT_BRK; other -> emit {code, ext=1, rel=1}, -> IDLE.
REQ-018 Special-byte discard (REQ-014) SHALL apply only in IDLE; in prefixed states those bytes are emitted as codes.
REQ-019 Timeout counter SHALL clear on every rx_done_tick and while in IDLE, increment each cycle otherwise; on reaching TIMEOUT_CYCLES-1 FSM -> IDLE, pending prefix dropped, no event.
REQ-020 Emitted event SHALL be written into FIFO at the clock edge sampling rx_done_tick (cycle N); key_valid=1 with that event at head from cycle N+1 if FIFO was empty (first-word fall-through).
REQ-021 Pop SHALL occur on any cycle with key_valid=1 and key_ready=1; next entry (if any) at head the following cycle.
REQ-022 While key_valid=1 and key_ready=0, key_code/key_ext/key_release SHALL remain stable.
REQ-023 Events SHALL be delivered in arrival order.
REQ-024 FIFO full and write without simultaneous pop: new event dropped, FIFO unchanged, overflow=1 for exactly cycle N+1.
REQ-025 FIFO full and write with simultaneous pop: both performed, no overflow.
REQ-026 FIFO empty: key_valid=0; pop ignored; key_code/key_ext/key_release values are don't-care.
REQ-027 Occupancy counter SHALL be log2(DEPTH)+1 bits; read/write pointers log2(DEPTH) bits, wrapping DEPTH-1 -> 0.

Reset
REQ-028 rst_n=0 at a clock edge SHALL set FSM=IDLE, timeout counter=0, FIFO empty (pointers, count=0), key_valid=0, overflow=0, key_code=8'h00, key_ext=0, key_release=0.
REQ-029 Reset mid-sequence SHALL discard pending prefix, all FIFO contents, and any rx_done_tick sampled in the reset cycle.

Verification
REQ-030 Make: key_ready=1, byte 1C -> key_valid=1 next cycle with key_code=1C, key_ext=0, key_release=0, popped in one cycle.
REQ-031 Break/extended: F0,1C -> {1C,0,1}; E0,75 -> {75,1,0}; E0,F0,75 -> {75,1,1}; FSM back to IDLE after each.
REQ-032 Overflow: DEPTH=4, key_ready=0, send 1C,32,21,23,24 -> 4 events held, overflow pulse after 24; key_ready=1 -> 1C,32,21,23 in order, then key_valid=0.
REQ-033 Timeout: TIMEOUT_CYCLES=16, send E0, idle 16 cycles, send 1C -> {1C,0,0}; same with 10 idle cycles -> {1C,1,0}.
REQ-034 Filtering/reset: AA, FA in IDLE -> no event; F0 then rst_n=0 one cycle then 1C -> {1C,0,0}; reset with 3 queued events -> key_valid=0.

Source files
------------

// File: rtl/keyboard_code_if.sv
// Keyboard decoder handshake bundle: PS/2 receiver byte strobe in, decoded key events out.
interface keyboard_code_if;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       key_ready;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       overflow;

  modport master (
    output rx_done_tick, dout, key_ready,
    input  key_valid, key_code, key_ext, key_release, overflow
  );
  modport slave (
    input  rx_done_tick, dout, key_ready,
    output key_valid, key_code, key_ext, key_release, overflow
  );
endinterface

// File: rtl/keyboard_code_ctrl.sv
// PS/2 scan-code decoder: strips E0/F0 prefixes and queues {code, ext, release}
// events into a first-word fall-through FIFO.
module keyboard_code_ctrl #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  keyboard_code_if.slave  kb
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } kev_t;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic          emit;
  kev_t          ev;

  logic          is_e0, is_f0, is_special;

  assign is_e0      = (kb.dout == 8'hE0);
  assign is_f0      = (kb.dout == 8'hF0);
  assign is_special = kb.dout inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  assign to_hit     = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Prefix flags are carried by the current state, so the event fields fall out of it directly.
  assign ev.code = kb.dout;
  assign ev.ext  = (state == EXT) || (state == EXT_BRK);
  assign ev.rel  = (state == BRK) || (state == EXT_BRK);

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    if (kb.rx_done_tick) begin
      unique case (state)
        IDLE: begin
          if (is_e0)            state_nxt = EXT;
          else if (is_f0)       state_nxt = BRK;
          else if (!is_special) emit = 1'b1;
        end
        EXT: begin
          if (is_f0)      state_nxt = EXT_BRK;
          else if (!is_e0) begin
            emit      = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          if (is_e0)      state_nxt = EXT_BRK;
          else if (!is_f0) begin
            emit      = 1'b1;
            state_nxt = IDLE;
          end
        end
        EXT_BRK: begin
          if (!is_e0 && !is_f0) begin
            emit      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (to_hit) begin
      // Stale prefix: the byte it qualified never came, so drop it silently.
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      to_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (kb.rx_done_tick || state == IDLE) to_cnt <= '0;
      else                                  to_cnt <= to_cnt + TW'(1);
    end
  end

  // Event FIFO
  kev_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, pop, push, drop, ovf;
  kev_t          head;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = !empty && kb.key_ready;
  assign push  = emit && (!full || pop);
  assign drop  = emit && full && !pop;

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= ev;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= drop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Head is forced to zero while empty so reset leaves clean outputs without clearing the array.
  assign head           = empty ? '0 : mem[rd_ptr];
  assign kb.key_valid   = !empty;
  assign kb.key_code    = head.code;
  assign kb.key_ext     = head.ext;
  assign kb.key_release = head.rel;
  assign kb.overflow    = ovf;
endmodule

// File: tb/tb_keyboard_code_ctrl.sv
// Directed + randomized bench for keyboard_code_ctrl against a prefix-flag/queue reference model.
module tb_keyboard_code_ctrl;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  keyboard_code_if kif();

  keyboard_code_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kb   (kif.slave)
  );

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } ev_t;

  ev_t q[$];
  bit  m_ext, m_brk, exp_ovf;
  int  idle_cnt;
  int  n_vec = 0;
  int  n_err = 0;

  function automatic bit special(logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("key_valid", 32'(kif.key_valid), 32'(q.size() != 0));
    chk("overflow",  32'(kif.overflow),  32'(exp_ovf));
    if (q.size() != 0) begin
      chk("key_code",    32'(kif.key_code),    32'(q[0].code));
      chk("key_ext",     32'(kif.key_ext),     32'(q[0].ext));
      chk("key_release", 32'(kif.key_release), 32'(q[0].rel));
    end
  endtask

  // Reference: prefixes are two sticky flags, timeout is "TMO idle cycles since last byte".
  task automatic model(bit tick, logic [7:0] b, bit rdy, bit rst);
    bit  pop, was_full, emit;
    ev_t e;
    if (!rst) begin
      q.delete();
      m_ext = 0; m_brk = 0; idle_cnt = 0; exp_ovf = 0;
      return;
    end
    pop      = (q.size() != 0) && rdy;
    was_full = (q.size() == DEPTH);
    emit     = 0;
    if (tick) begin
      idle_cnt = 0;
      if (b == 8'hE0)                      m_ext = 1;
      else if (b == 8'hF0)                 m_brk = 1;
      else if (!m_ext && !m_brk && special(b)) emit = 0;
      else begin
        emit = 1;
        e.code = b; e.ext = m_ext; e.rel = m_brk;
        m_ext = 0; m_brk = 0;
      end
    end else begin
      idle_cnt++;
      if (idle_cnt >= TMO) begin m_ext = 0; m_brk = 0; end
    end
    exp_ovf = emit && was_full && !pop;
    if (pop) void'(q.pop_front());
    if (emit && !(was_full && !pop)) q.push_back(e);
  endtask

  task automatic cyc(bit tick, logic [7:0] b, bit rdy, bit rst);
    @(negedge clk);
    check_outputs();
    kif.rx_done_tick = tick;
    kif.dout         = b;
    kif.key_ready    = rdy;
    rst_n            = rst;
    @(posedge clk);
    model(tick, b, rdy, rst);
  endtask

  task automatic send(logic [7:0] b, bit rdy);
    cyc(1'b1, b, rdy, 1'b1);
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, rdy, 1'b1);
  endtask

  initial begin
    logic [7:0] pool [8];
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'hAA; pool[3] = 8'hFA;
    pool[4] = 8'hFE; pool[5] = 8'hEE; pool[6] = 8'h00; pool[7] = 8'hFF;

    kif.rx_done_tick = 0; kif.dout = 8'h00; kif.key_ready = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    model(0, 8'h00, 0, 0);
    @(negedge clk);
    chk("rst key_valid",   32'(kif.key_valid),   32'(0));
    chk("rst overflow",    32'(kif.overflow),    32'(0));
    chk("rst key_code",    32'(kif.key_code),    32'(0));
    chk("rst key_ext",     32'(kif.key_ext),     32'(0));
    chk("rst key_release", 32'(kif.key_release), 32'(0));

    // make / break / extended, each followed by a plain byte to show the FSM returned to IDLE
    send(8'h1C, 1); idle(2, 1);
    send(8'hF0, 1); send(8'h1C, 1); idle(2, 1);
    send(8'hE0, 1); send(8'h75, 1); idle(2, 1);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1); idle(2, 1);
    send(8'hF0, 1); send(8'hE0, 1); send(8'hF0, 1); send(8'h6B, 1); idle(1, 1);
    send(8'h1C, 1); idle(2, 1);

    // overflow, then drain in order
    send(8'h1C, 0); send(8'h32, 0); send(8'h21, 0); send(8'h23, 0); send(8'h24, 0);
    idle(3, 0); idle(6, 1);

    // full with simultaneous pop
    send(8'h11, 0); send(8'h12, 0); send(8'h13, 0); send(8'h14, 0);
    send(8'h15, 1); idle(6, 1);

    // timeout: 16 idle drops prefix, 10 and 15 keep it
    send(8'hE0, 1); idle(16, 1); send(8'h1C, 1); idle(2, 1);
    send(8'hE0, 1); idle(10, 1); send(8'h1C, 1); idle(2, 1);
    send(8'hE0, 1); idle(15, 1); send(8'h1C, 1); idle(2, 1);
    send(8'hF0, 1); idle(16, 1); send(8'h1C, 1); idle(2, 1);

    // filtering only in IDLE
    send(8'hAA, 1); send(8'hFA, 1); idle(2, 1);
    send(8'hE0, 1); send(8'hAA, 1); send(8'hF0, 1); send(8'hFF, 1); idle(2, 1);

    // reset drops a pending prefix, a byte sampled in reset, and queued events
    send(8'hF0, 1); cyc(1, 8'h33, 1, 0); send(8'h1C, 1); idle(2, 1);
    send(8'h1C, 0); send(8'h32, 0); send(8'h21, 0); idle(1, 0);
    cyc(0, 8'h00, 0, 0); idle(3, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit         tick, rdy, rst;
      logic [7:0] b;
      tick = ($urandom % 3) == 0;
      b    = ($urandom % 3 == 0) ? pool[$urandom % 8] : 8'($urandom);
      rdy  = (i / 200) % 2 == 0 ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
      rst  = ($urandom % 300) != 0;
      if ($urandom % 150 == 0) idle($urandom_range(12, 20), rdy);
      cyc(tick, b, rdy, rst);
    end
    idle(8, 1);
    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
